// File: rtl/cell_alloc_rr_if.sv
// cell_alloc_rr_if: alloc/free handshake bundle between the enqueue/dequeue paths and the cell allocator
interface cell_alloc_rr_if #(
  parameter int CELL_ID_WIDTH = 6,
  parameter int FREE_PORT_NUM = 4
);
  logic alloc_req, alloc_prio, alloc_success, alloc_intense, init_done, err_double_free;
  logic [CELL_ID_WIDTH-1:0] alloc_cell_id;
  logic [FREE_PORT_NUM-1:0] free_valid, free_ready;
  logic [FREE_PORT_NUM*CELL_ID_WIDTH-1:0] free_cell_id;
  logic [CELL_ID_WIDTH:0] free_count;
  logic [7:0] err_count;
  modport master (
    output alloc_req, alloc_prio, free_valid, free_cell_id,
    input alloc_success, alloc_cell_id, alloc_intense, free_ready, free_count, init_done,
          err_double_free, err_count
  );
  modport slave (
    input alloc_req, alloc_prio, free_valid, free_cell_id,
    output alloc_success, alloc_cell_id, alloc_intense, free_ready, free_count, init_done,
           err_double_free, err_count
  );
endinterface

// File: rtl/cell_alloc_rr.sv
// cell_alloc_rr: circular free-list cell allocator with reserved priority cells and round-robin multi-port free
module cell_alloc_rr #(
  parameter int CELL_NUM = 64,
  parameter int CELL_ID_WIDTH = $clog2(CELL_NUM),
  parameter int FREE_PORT_NUM = 4,
  parameter int INTENSE_THRESH = 32,
  parameter int DROP_THRESH = 2
) (
  input logic clk,
  input logic rst,
  cell_alloc_rr_if.slave bus
);
  localparam int PW = FREE_PORT_NUM > 1 ? $clog2(FREE_PORT_NUM) : 1;
  localparam int CW = CELL_ID_WIDTH + 1;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_d;
  logic [CELL_ID_WIDTH-1:0] list [CELL_NUM];
  logic [CELL_ID_WIDTH-1:0] head, tail, fid, aid;
  logic [CELL_NUM-1:0] bitmap;
  logic [CW-1:0] count;
  logic [PW-1:0] rr, gnt, cand;
  logic any, fire, free_ok, free_bad, alloc, err_q;
  logic [7:0] errs;
  always_ff @(posedge clk)
    if (rst) state <= INIT;
    else state <= state_d;
  always_comb begin
    state_d = state;
    any = 1'b0;
    gnt = rr;
    cand = '0;
    for (int i = FREE_PORT_NUM; i >= 1; i--) begin
      cand = PW'((int'(rr) + i) % FREE_PORT_NUM);
      if (bus.free_valid[cand]) begin
        any = 1'b1;
        gnt = cand;
      end
    end
    if (state == INIT && tail == CELL_ID_WIDTH'(CELL_NUM - 1)) state_d = RUN;
    fire = state == RUN && any;
    fid = bus.free_cell_id[int'(gnt)*CELL_ID_WIDTH +: CELL_ID_WIDTH];
    free_ok = fire && bitmap[fid];
    free_bad = fire && !bitmap[fid];
    aid = list[head];
    alloc = state == RUN && bus.alloc_req &&
            (count > CW'(DROP_THRESH) || (bus.alloc_prio && count != '0));
    bus.alloc_success = alloc;
    bus.alloc_cell_id = aid;
    bus.free_ready = fire ? FREE_PORT_NUM'(1) << gnt : '0;
    bus.init_done = state == RUN;
    bus.alloc_intense = count <= CW'(INTENSE_THRESH);
    bus.free_count = count;
    bus.err_double_free = err_q;
    bus.err_count = errs;
  end
  // tail doubles as the init write pointer; it wraps back to 0 as INIT ends
  always_ff @(posedge clk)
    if (state == INIT) list[tail] <= tail;
    else if (free_ok) list[tail] <= fid;
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      bitmap <= '0;
      count <= '0;
      rr <= PW'(FREE_PORT_NUM - 1);
      err_q <= 1'b0;
      errs <= '0;
    end else begin
      err_q <= free_bad;
      if (free_bad && errs != 8'hff) errs <= errs + 8'd1;
      if (state == INIT) begin
        tail <= tail + 1'b1;
        count <= count + 1'b1;
      end else begin
        if (alloc) head <= head + 1'b1;
        if (free_ok) tail <= tail + 1'b1;
        if (fire) rr <= gnt;
        if (alloc) bitmap[aid] <= 1'b1;
        if (free_ok) bitmap[fid] <= 1'b0;
        count <= count + CW'(free_ok) - CW'(alloc);
      end
    end
  end
endmodule

// File: tb/tb_cell_alloc_rr.sv
// tb_cell_alloc_rr: directed scenario tests for the cell allocator
module tb_cell_alloc_rr;
  localparam int W = 6, P = 4;
  logic clk = 1'b0, rst = 1'b1;
  int tests = 0, fails = 0;
  cell_alloc_rr_if #(.CELL_ID_WIDTH(W), .FREE_PORT_NUM(P)) bus ();
  cell_alloc_rr dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic wait_init(output int cyc, output bit quiet);
    cyc = 0;
    quiet = 1'b1;
    while (bus.init_done !== 1'b1 && cyc < 200) begin
      if (bus.alloc_success !== 1'b0 || bus.free_ready !== 4'd0) quiet = 1'b0;
      @(posedge clk); cyc++; #1;
    end
  endtask

  task automatic test_reset();
    int cyc;
    bit quiet;
    rst = 1'b1;
    bus.alloc_req = 1'b1; bus.alloc_prio = 1'b1; bus.free_valid = '1; bus.free_cell_id = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if (bus.free_count !== 7'd0 || bus.init_done !== 1'b0 || bus.alloc_success !== 1'b0 ||
        bus.free_ready !== 4'd0 || bus.err_count !== 8'd0 || bus.err_double_free !== 1'b0) begin
      fails++;
      $display("FAIL reset: fc=%0d done=%b succ=%b rdy=%b errc=%0d errp=%b, required all 0",
               bus.free_count, bus.init_done, bus.alloc_success, bus.free_ready, bus.err_count, bus.err_double_free);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init(cyc, quiet);
    bus.alloc_req = 1'b0; bus.alloc_prio = 1'b0; bus.free_valid = '0;
    tests++;
    if (cyc !== 64) begin fails++; $display("FAIL init_latency: got %0d cycles, required 64", cyc); end
    tests++;
    if (!quiet) begin fails++; $display("FAIL init_quiet: grant seen during INIT, required none"); end
    @(negedge clk);
    tests++;
    if (bus.free_count !== 7'd64 || bus.alloc_intense !== 1'b0) begin
      fails++;
      $display("FAIL init_count: fc=%0d intense=%b, required 64/0", bus.free_count, bus.alloc_intense);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alloc_normal();
    bus.alloc_req = 1'b1; bus.alloc_prio = 1'b0;
    for (int i = 0; i < 62; i++) begin
      @(negedge clk);
      tests++;
      if (bus.alloc_success !== 1'b1 || bus.alloc_cell_id !== W'(i)) begin
        fails++;
        $display("FAIL alloc_%0d: succ=%b id=%0d, required 1/%0d", i, bus.alloc_success, bus.alloc_cell_id, i);
      end
      tests++;
      if (bus.alloc_intense !== ((64 - i) <= 32)) begin
        fails++;
        $display("FAIL intense_fc%0d: got %b, required %b", 64 - i, bus.alloc_intense, (64 - i) <= 32);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests++;
    if (bus.free_count !== 7'd2 || bus.alloc_success !== 1'b0) begin
      fails++;
      $display("FAIL reserve_refuse: fc=%0d succ=%b, required 2/0", bus.free_count, bus.alloc_success);
    end
    @(posedge clk); #1;
    bus.alloc_req = 1'b0;
  endtask

  task automatic test_alloc_prio();
    bus.alloc_req = 1'b1; bus.alloc_prio = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++;
      if (bus.alloc_success !== 1'b1 || bus.alloc_cell_id !== W'(62 + k)) begin
        fails++;
        $display("FAIL prio_%0d: succ=%b id=%0d, required 1/%0d", k, bus.alloc_success, bus.alloc_cell_id, 62 + k);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests++;
    if (bus.free_count !== 7'd0 || bus.alloc_success !== 1'b0) begin
      fails++;
      $display("FAIL prio_empty: fc=%0d succ=%b, required 0/0", bus.free_count, bus.alloc_success);
    end
    @(posedge clk); #1;
    bus.alloc_req = 1'b0; bus.alloc_prio = 1'b0;
  endtask

  task automatic test_rr_free();
    int ids [P];
    for (int p = 0; p < P; p++) begin
      ids[p] = p;
      bus.free_cell_id[p*W +: W] = W'(p);
    end
    bus.free_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tests++;
      if (bus.free_ready !== 4'(1 << (k % 4)) || bus.free_count !== 7'(k)) begin
        fails++;
        $display("FAIL rr_%0d: rdy=%b fc=%0d, required %b/%0d", k, bus.free_ready, bus.free_count, 4'(1 << (k % 4)), k);
      end
      @(posedge clk); #1;
      ids[k % 4] += 4;
      bus.free_cell_id[(k % 4)*W +: W] = W'(ids[k % 4]);
    end
    bus.free_valid = '0;
    @(negedge clk);
    tests++;
    if (bus.free_count !== 7'd8 || bus.err_count !== 8'd0) begin
      fails++;
      $display("FAIL rr_total: fc=%0d errc=%0d, required 8/0", bus.free_count, bus.err_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_double_free();
    bus.free_valid = 4'b0001;
    bus.free_cell_id[0 +: W] = W'(5);
    @(negedge clk);
    tests++;
    if (bus.free_ready !== 4'b0001 || bus.err_double_free !== 1'b0) begin
      fails++;
      $display("FAIL dbl_accept: rdy=%b errp=%b, required 0001/0", bus.free_ready, bus.err_double_free);
    end
    @(posedge clk); #1;
    bus.free_valid = '0;
    @(negedge clk);
    tests++;
    if (bus.err_double_free !== 1'b1 || bus.err_count !== 8'd1 || bus.free_count !== 7'd8) begin
      fails++;
      $display("FAIL dbl_err: errp=%b errc=%0d fc=%0d, required 1/1/8", bus.err_double_free, bus.err_count, bus.free_count);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (bus.err_double_free !== 1'b0) begin fails++; $display("FAIL dbl_pulse: errp=%b, required 0", bus.err_double_free); end
    @(posedge clk); #1;
  endtask

  task automatic test_simul();
    bus.free_valid = 4'b0010;
    bus.free_cell_id[W +: W] = W'(8);
    @(posedge clk); #1;
    bus.free_cell_id[W +: W] = W'(9);
    @(posedge clk); #1;
    bus.free_cell_id[W +: W] = W'(10);
    bus.alloc_req = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.free_count !== 7'd10 || bus.alloc_success !== 1'b1 || bus.alloc_cell_id !== W'(0) || bus.free_ready !== 4'b0010) begin
      fails++;
      $display("FAIL simul_pre: fc=%0d succ=%b id=%0d rdy=%b, required 10/1/0/0010",
               bus.free_count, bus.alloc_success, bus.alloc_cell_id, bus.free_ready);
    end
    @(posedge clk); #1;
    bus.free_cell_id[W +: W] = W'(1);
    @(negedge clk);
    tests++;
    if (bus.free_count !== 7'd10 || bus.alloc_cell_id !== W'(1) || bus.err_count !== 8'd1) begin
      fails++;
      $display("FAIL simul_post: fc=%0d id=%0d errc=%0d, required 10/1/1", bus.free_count, bus.alloc_cell_id, bus.err_count);
    end
    @(posedge clk); #1;
    bus.alloc_req = 1'b0; bus.free_valid = '0;
    @(negedge clk);
    tests++;
    if (bus.free_count !== 7'd9 || bus.err_double_free !== 1'b1 || bus.err_count !== 8'd2) begin
      fails++;
      $display("FAIL same_id: fc=%0d errp=%b errc=%0d, required 9/1/2", bus.free_count, bus.err_double_free, bus.err_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit quiet;
    bus.alloc_req = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (bus.init_done !== 1'b0 || bus.free_count !== 7'd0 || bus.alloc_success !== 1'b0 || bus.err_count !== 8'd0) begin
      fails++;
      $display("FAIL mid_reset: done=%b fc=%0d succ=%b errc=%0d, required 0/0/0/0",
               bus.init_done, bus.free_count, bus.alloc_success, bus.err_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init(cyc, quiet);
    tests++;
    if (cyc !== 64 || !quiet) begin fails++; $display("FAIL reinit: cycles=%0d quiet=%b, required 64/1", cyc, quiet); end
    @(negedge clk);
    tests++;
    if (bus.alloc_success !== 1'b1 || bus.alloc_cell_id !== W'(0) || bus.free_count !== 7'd64) begin
      fails++;
      $display("FAIL reinit_alloc: succ=%b id=%0d fc=%0d, required 1/0/64", bus.alloc_success, bus.alloc_cell_id, bus.free_count);
    end
    @(posedge clk); #1;
    bus.alloc_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alloc_normal();
    test_alloc_prio();
    test_rr_free();
    test_double_free();
    test_simul();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
